// File: rtl/rx_frame_timing_counter.sv
// Per-frame RX timing: oversampling edge count, bit position, mid-bit sample
// strobes, bit/frame completion and field decode, with config latched per frame.
module rx_frame_timing_counter #(
  parameter int PRESCALE_WIDTH = 6,
  parameter int BIT_CNT_WIDTH  = 4,
  parameter int MAX_DATA_BITS  = 9,
  parameter int DATA_IDX_WIDTH = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      enable,
  input  logic                      restart,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic [3:0]                data_bits,
  input  logic                      PAR_EN,
  input  logic                      stop2,
  output logic [PRESCALE_WIDTH-1:0] edge_cnt,
  output logic [BIT_CNT_WIDTH-1:0]  bit_cnt,
  output logic [1:0]                field,
  output logic [DATA_IDX_WIDTH-1:0] data_idx,
  output logic                      sample_stb,
  output logic                      sample_last,
  output logic                      bit_done,
  output logic                      frame_done
);

  localparam logic [PRESCALE_WIDTH-1:0] PRESC_ONE  = PRESCALE_WIDTH'(1);
  localparam logic [PRESCALE_WIDTH-1:0] PRESC_MIN  = PRESCALE_WIDTH'(4);
  localparam logic [PRESCALE_WIDTH-1:0] PRESC_RST  = PRESCALE_WIDTH'(8);
  localparam logic [BIT_CNT_WIDTH-1:0]  BIT_ONE    = BIT_CNT_WIDTH'(1);
  localparam logic [BIT_CNT_WIDTH-1:0]  BIT_TWO    = BIT_CNT_WIDTH'(2);
  localparam logic [3:0]                DBITS_MIN  = 4'd5;
  localparam logic [3:0]                DBITS_MAX  = 4'(MAX_DATA_BITS);
  localparam logic [3:0]                DBITS_RST  = 4'd8;

  logic [PRESCALE_WIDTH-1:0] edge_cnt_r;
  logic [BIT_CNT_WIDTH-1:0]  bit_cnt_r;
  logic                      active_r;
  logic [PRESCALE_WIDTH-1:0] presc_l_r;
  logic [3:0]                dbits_l_r;
  logic                      par_l_r;
  logic                      stop2_l_r;

  logic [PRESCALE_WIDTH-1:0] presc_in_s;
  logic [3:0]                dbits_in_s;
  logic [PRESCALE_WIDTH-1:0] presc_s;
  logic [3:0]                dbits_s;
  logic                      par_s;
  logic                      stop2_s;
  logic [BIT_CNT_WIDTH-1:0]  fl_s;
  logic [PRESCALE_WIDTH-1:0] mid_s;
  logic                      edge_wrap_s;
  logic                      bit_last_s;

  // Clamp the raw inputs and pick the config in force: the inputs themselves on the
  // cycle they get latched, so the first cycle of a frame already decodes correctly.
  always_comb begin
    presc_in_s = prescale;
    dbits_in_s = data_bits;
    if (prescale < PRESC_MIN) begin
      presc_in_s = PRESC_MIN;
    end else begin
      presc_in_s = prescale;
    end
    if (data_bits < DBITS_MIN) begin
      dbits_in_s = DBITS_MIN;
    end else if (data_bits > DBITS_MAX) begin
      dbits_in_s = DBITS_MAX;
    end else begin
      dbits_in_s = data_bits;
    end
    if (active_r) begin
      presc_s = presc_l_r;
      dbits_s = dbits_l_r;
      par_s   = par_l_r;
      stop2_s = stop2_l_r;
    end else begin
      presc_s = presc_in_s;
      dbits_s = dbits_in_s;
      par_s   = PAR_EN;
      stop2_s = stop2;
    end
    fl_s = BIT_ONE + BIT_CNT_WIDTH'(dbits_s) + BIT_CNT_WIDTH'(par_s)
         + (stop2_s ? BIT_TWO : BIT_ONE);
    mid_s       = presc_s >> 1;
    edge_wrap_s = (edge_cnt_r >= presc_s);
    bit_last_s  = (bit_cnt_r >= fl_s);
  end

  // Counter and config-latch state; restart outranks enable, RST outranks all.
  always_ff @(posedge CLK) begin
    if (RST) begin
      edge_cnt_r <= PRESC_ONE;
      bit_cnt_r  <= BIT_ONE;
      active_r   <= 1'b0;
      presc_l_r  <= PRESC_RST;
      dbits_l_r  <= DBITS_RST;
      par_l_r    <= 1'b0;
      stop2_l_r  <= 1'b0;
    end else if (restart) begin
      edge_cnt_r <= PRESC_ONE;
      bit_cnt_r  <= BIT_ONE;
      active_r   <= 1'b1;
      presc_l_r  <= presc_in_s;
      dbits_l_r  <= dbits_in_s;
      par_l_r    <= PAR_EN;
      stop2_l_r  <= stop2;
    end else if (!enable) begin
      edge_cnt_r <= PRESC_ONE;
      bit_cnt_r  <= BIT_ONE;
      active_r   <= 1'b0;
    end else begin
      if (!active_r) begin
        active_r  <= 1'b1;
        presc_l_r <= presc_in_s;
        dbits_l_r <= dbits_in_s;
        par_l_r   <= PAR_EN;
        stop2_l_r <= stop2;
      end else begin
        active_r <= 1'b1;
      end
      if (edge_wrap_s) begin
        edge_cnt_r <= PRESC_ONE;
        if (bit_last_s) begin
          bit_cnt_r <= BIT_ONE;
          active_r  <= 1'b0;
        end else begin
          bit_cnt_r <= bit_cnt_r + BIT_ONE;
        end
      end else begin
        edge_cnt_r <= edge_cnt_r + PRESC_ONE;
      end
    end
  end

  // Strobes and field decode, aligned with the counter values shown this cycle.
  always_comb begin
    sample_stb  = 1'b0;
    sample_last = 1'b0;
    bit_done    = 1'b0;
    frame_done  = 1'b0;
    field       = 2'd0;
    data_idx    = {DATA_IDX_WIDTH{1'b0}};
    if (enable) begin
      sample_stb  = (edge_cnt_r == mid_s - PRESC_ONE) || (edge_cnt_r == mid_s)
                 || (edge_cnt_r == mid_s + PRESC_ONE);
      sample_last = (edge_cnt_r == mid_s + PRESC_ONE);
      bit_done    = (edge_cnt_r == presc_s);
      frame_done  = (edge_cnt_r == presc_s) && (bit_cnt_r == fl_s);
      if (bit_cnt_r == BIT_ONE) begin
        field = 2'd0;
      end else if (bit_cnt_r <= BIT_CNT_WIDTH'(dbits_s) + BIT_ONE) begin
        field    = 2'd1;
        data_idx = DATA_IDX_WIDTH'(bit_cnt_r - BIT_TWO);
      end else if (par_s && (bit_cnt_r == BIT_CNT_WIDTH'(dbits_s) + BIT_TWO)) begin
        field = 2'd2;
      end else begin
        field = 2'd3;
      end
    end else begin
      field = 2'd0;
    end
  end

  assign edge_cnt = edge_cnt_r;
  assign bit_cnt  = bit_cnt_r;

endmodule

// File: tb/tb_rx_frame_timing_counter.sv
// Scoreboard bench: stimulus pushes the expected per-bit completion records,
// a negedge monitor pops one on every bit_done and compares.
module tb_rx_frame_timing_counter;

  logic       CLK = 1'b0;
  logic       RST;
  logic       enable;
  logic       restart;
  logic [5:0] prescale;
  logic [3:0] data_bits;
  logic       PAR_EN;
  logic       stop2;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic [1:0] field;
  logic [3:0] data_idx;
  logic       sample_stb;
  logic       sample_last;
  logic       bit_done;
  logic       frame_done;

  typedef struct {
    int cyc;
    int edge_v;
    int bit_v;
    int field_v;
    int idx_v;
    int fdone;
    int stb_first;
    int stb_last;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   p0;

  rx_frame_timing_counter dut (
    .CLK(CLK), .RST(RST), .enable(enable), .restart(restart),
    .prescale(prescale), .data_bits(data_bits), .PAR_EN(PAR_EN), .stop2(stop2),
    .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .field(field), .data_idx(data_idx),
    .sample_stb(sample_stb), .sample_last(sample_last),
    .bit_done(bit_done), .frame_done(frame_done)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // fields: hand-written field code per bit position; its length is the frame length
  task automatic push_frame(input string fields, input int p, input int sfirst,
                            input int slast, input int limit, input int start);
    exp_t e;
    int   idx;
    idx = 0;
    for (int pos = 1; pos <= fields.len() && pos <= limit; pos++) begin
      e.bit_v     = pos;
      e.cyc       = start + p * pos - 1;
      e.edge_v    = p;
      e.field_v   = int'(fields[pos-1]) - 48;
      e.idx_v     = (e.field_v == 1) ? idx : 0;
      e.fdone     = (pos == fields.len()) ? 1 : 0;
      e.stb_first = sfirst;
      e.stb_last  = slast;
      if (e.field_v == 1) idx++;
      sb_q.push_back(e);
    end
  endtask

  // monitor: tracks sample strobes within the current bit, checks on bit_done
  initial begin
    int   stb_cnt;
    int   stb_first;
    int   stb_last;
    exp_t e;
    stb_cnt = 0;
    stb_first = 0;
    stb_last = 0;
    forever begin
      @(negedge CLK);
      if (edge_cnt == 6'd1) begin
        stb_cnt = 0;
        stb_first = 0;
        stb_last = 0;
      end
      if (sample_stb === 1'b1) begin
        if (stb_cnt == 0) stb_first = int'(edge_cnt);
        stb_cnt++;
      end
      if (sample_last === 1'b1) stb_last = int'(edge_cnt);
      if (frame_done === 1'b1 && bit_done !== 1'b1) begin
        n_checks++;
        n_fail++;
        $display("FAIL frame_done_without_bit_done: bit_cnt %0d", bit_cnt);
      end
      if (bit_done === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_bit_done: got bit_cnt %0d frame_done %0d, expected none",
                   bit_cnt, frame_done);
        end else begin
          e = sb_q.pop_front();
          check("bit_done_cycle", cyc, e.cyc);
          check("edge_cnt", int'(edge_cnt), e.edge_v);
          check("bit_cnt", int'(bit_cnt), e.bit_v);
          check("field", int'(field), e.field_v);
          check("data_idx", int'(data_idx), e.idx_v);
          check("frame_done", int'(frame_done), e.fdone);
          check("sample_count", stb_cnt, 3);
          check("sample_first_edge", stb_first, e.stb_first);
          check("sample_last_edge", stb_last, e.stb_last);
        end
      end
    end
  end

  initial begin
    RST = 1'b1; enable = 1'b0; restart = 1'b0;
    prescale = 6'd8; data_bits = 4'd8; PAR_EN = 1'b0; stop2 = 1'b0;
    step(3);
    check("rst_edge_cnt", int'(edge_cnt), 1);
    check("rst_bit_cnt", int'(bit_cnt), 1);
    check("rst_field", int'(field), 0);
    check("rst_data_idx", int'(data_idx), 0);
    check("rst_strobes", int'({sample_stb, sample_last, bit_done, frame_done}), 0);

    // frame 1: 8x oversampling, 8N1 -> 10 bits, 80 cycles
    RST = 1'b0; enable = 1'b1;
    p0 = cyc;
    push_frame("0111111113", 8, 3, 5, 99, p0);
    step(80);

    // frame 2: same timing, inputs change at bit 4 and must not affect it
    p0 = cyc;
    push_frame("0111111113", 8, 3, 5, 99, p0);
    step(25);
    check("f2_edge_at_change", int'(edge_cnt), 2);
    check("f2_bit_at_change", int'(bit_cnt), 4);
    prescale = 6'd16; data_bits = 4'd7; PAR_EN = 1'b1; stop2 = 1'b1;
    step(55);

    // frame 3: 16x, 7 data, parity, 2 stop -> 11 bits, 176 cycles
    p0 = cyc;
    push_frame("01111111233", 16, 7, 9, 99, p0);
    step(50);
    prescale = 6'd8; data_bits = 4'd8; PAR_EN = 1'b0; stop2 = 1'b0;
    step(126);

    // frame 4: aborted by restart at bit 5 edge 6
    p0 = cyc;
    push_frame("0111111113", 8, 3, 5, 4, p0);
    step(37);
    check("f4_edge_before_restart", int'(edge_cnt), 6);
    check("f4_bit_before_restart", int'(bit_cnt), 5);
    check("f4_data_idx", int'(data_idx), 3);
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    check("restart_edge_cnt", int'(edge_cnt), 1);
    check("restart_bit_cnt", int'(bit_cnt), 1);
    check("restart_field", int'(field), 0);
    check("restart_frame_done", int'(frame_done), 0);

    // frame 5: enable dropped at bit 3 edge 4 (a sample edge)
    p0 = cyc;
    push_frame("0111111113", 8, 3, 5, 2, p0);
    step(19);
    check("f5_edge_before_drop", int'(edge_cnt), 4);
    check("f5_bit_before_drop", int'(bit_cnt), 3);
    enable = 1'b0;
    #1;
    check("disabled_strobes", int'({sample_stb, sample_last, bit_done, frame_done}), 0);
    check("disabled_field", int'(field), 0);
    step(1);
    check("disabled_edge_cnt", int'(edge_cnt), 1);
    check("disabled_bit_cnt", int'(bit_cnt), 1);
    step(2);

    // reset together with restart: reset must win, leaving the block idle
    RST = 1'b1; restart = 1'b1; enable = 1'b1; prescale = 6'd2; data_bits = 4'd12;
    step(1);
    RST = 1'b0; restart = 1'b0; prescale = 6'd8; data_bits = 4'd8;
    check("rst_restart_edge_cnt", int'(edge_cnt), 1);
    check("rst_restart_bit_cnt", int'(bit_cnt), 1);

    // frame 6: latched fresh on the first enabled cycle as 8N1
    p0 = cyc;
    push_frame("0111111113", 8, 3, 5, 99, p0);
    step(40);
    prescale = 6'd2; data_bits = 4'd12;
    step(40);

    // frame 7: prescale 2 -> 4, data_bits 12 -> 9, 11 bits, 44 cycles
    p0 = cyc;
    push_frame("01111111113", 4, 1, 3, 99, p0);
    step(44);
    enable = 1'b0;
    step(3);

    for (int i = 0; i < 100 && sb_q.size() > 0; i++) step(1);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
